// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU logic units.
//   DATA_W  : default datapath width used by the ALU units
//   cnt_w() : width needed to hold a set-bit count of an n-bit word (0..n)
//   CNT_W   : count width for the default datapath width
//   word_t  : a default-width datapath word
//   aluFlags_t : zero/sign flag pair produced alongside a result
// No ports; imported by the units that need these definitions.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;

    // A count of set bits in an n-bit word ranges over 0..n inclusive, so it
    // needs clog2(n+1) bits rather than clog2(n).
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_w(DATA_W);

    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        logic zero;
        logic neg;
    } aluFlags_t;

endpackage

// File: rtl/and32_bit_popcount_tree.sv
// ---------------------------------------------------------------------------
// popcount_tree
// Purely combinational set-bit counter built as a balanced adder tree.
// Shared with the other ALU units that report a population count.
// Parameters:
//   N        : input width in bits (2 or more)
// Ports:
//   data_i   : input  [N-1:0]            word to count
//   count_o  : output [clog2(N+1)-1:0]   number of set bits in data_i
// ---------------------------------------------------------------------------
import alu_pkg::*;

module popcount_tree #(
    parameter int N = DATA_W
) (
    input  logic [N-1:0]            data_i,
    output logic [$clog2(N+1)-1:0]  count_o
);

    localparam int CW   = cnt_w(N);
    localparam int LVLS = $clog2(N);
    localparam int P    = 1 << LVLS;

    // Every node is kept at the final count width.  No partial sum can
    // exceed N, so nothing overflows, and uniform widths keep the tree
    // regular for any N.
    logic [CW-1:0] node [LVLS+1][P];

    // Leaf level: one node per input bit, padded up to a power of two with
    // zero leaves so the tree halves cleanly at every level.
    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < N) begin : g_bit
            assign node[0][i] = CW'(data_i[i]);
        end else begin : g_pad
            assign node[0][i] = '0;
        end
    end

    // Each level sums adjacent pairs from the level below.  Node slots
    // that the halved level no longer needs are tied off to zero.
    for (genvar l = 1; l <= LVLS; l++) begin : g_level
        for (genvar j = 0; j < P; j++) begin : g_node
            if (j < (P >> l)) begin : g_sum
                assign node[l][j] = node[l-1][2*j] + node[l-1][2*j+1];
            end else begin : g_unused
                assign node[l][j] = '0;
            end
        end
    end

    assign count_o = node[LVLS][0];

endmodule

// File: rtl/and32_bit.sv
// ---------------------------------------------------------------------------
// and32_bit
// Registered bitwise AND unit of the ALU datapath.  Produces A & B one cycle
// after the operands are presented, together with zero/sign flags and the
// set-bit count of the result.  All four result outputs come from the same
// register stage, so they always describe the same result.
// Parameters:
//   N          : operand/result width (2..64), defaults to DATA_W
// Ports:
//   clk        : input               rising-edge clock
//   rst_n      : input               synchronous active-low reset
//   A, B       : input  [N-1:0]      operands
//   in_valid   : input               A and B are valid this cycle
//   F          : output [N-1:0]      registered A & B
//   out_valid  : output              one-cycle pulse per accepted pair
//   ZERO       : output              registered (F == 0)
//   NEG        : output              registered F[N-1]
//   ONES       : output [clog2(N+1)-1:0] registered set-bit count of F
// ---------------------------------------------------------------------------
import alu_pkg::*;

module and32_bit #(
    parameter int N = DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            A,
    input  logic [N-1:0]            B,
    input  logic                    in_valid,
    output logic [N-1:0]            F,
    output logic                    out_valid,
    output logic                    ZERO,
    output logic                    NEG,
    output logic [$clog2(N+1)-1:0]  ONES
);

    localparam int CW = cnt_w(N);

    logic [N-1:0]  andWord;
    logic [CW-1:0] andOnes;
    aluFlags_t     andFlags;

    logic [N-1:0]  result_q, result_d;
    aluFlags_t     flags_q,  flags_d;
    logic [CW-1:0] ones_q,   ones_d;
    logic          valid_q,  valid_d;

    // The AND array: each result bit depends only on its own operand bits.
    assign andWord = A & B;

    popcount_tree #(
        .N       (N)
    ) u_popcount (
        .data_i  (andWord),
        .count_o (andOnes)
    );

    // Flags are derived from the combinational AND result so they land in
    // the same register stage as F itself.
    always_comb begin
        andFlags      = '0;
        andFlags.zero = ~|andWord;
        andFlags.neg  = andWord[N-1];
    end

    // Next-state: accept a new operand pair when in_valid is high; otherwise
    // hold the last result and drop out_valid so it pulses once per pair.
    // Operands are ignored entirely while in_valid is low.
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        ones_d   = ones_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            result_d = andWord;
            flags_d  = andFlags;
            ones_d   = andOnes;
            valid_d  = 1'b1;
        end
    end

    // Output registers.  Reset wins over in_valid on the same edge and
    // leaves the unit looking like it holds a zero result (ZERO set).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q     <= '0;
            flags_q.zero <= 1'b1;
            flags_q.neg  <= 1'b0;
            ones_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            result_q     <= result_d;
            flags_q      <= flags_d;
            ones_q       <= ones_d;
            valid_q      <= valid_d;
        end
    end

    assign F         = result_q;
    assign ZERO      = flags_q.zero;
    assign NEG       = flags_q.neg;
    assign ONES      = ones_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_and32_bit.sv
// ---------------------------------------------------------------------------
// tb_and32_bit
// Self-checking bench for and32_bit.  Two instances share the stimulus: the
// default 32-bit unit and an 8-bit unit fed with the low operand bytes.
// Every driven cycle pushes the expected post-edge outputs of both units
// onto a scoreboard; a monitor pops one entry after each rising edge and
// compares every output.
// ---------------------------------------------------------------------------
module tb_and32_bit;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic [31:0] opA, opB;

    logic [31:0] f32;
    logic        valid32, zero32, neg32;
    logic [5:0]  ones32;

    logic [7:0]  f8;
    logic        valid8, zero8, neg8;
    logic [3:0]  ones8;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [31:0] f32;
        logic        z32;
        logic        n32;
        logic [5:0]  o32;
        logic        v32;
        logic [7:0]  f8;
        logic        z8;
        logic        n8;
        logic [3:0]  o8;
        logic        v8;
    } expT;

    expT sb[$];

    // Reference model state, advanced once per driven cycle.
    logic [31:0] mF32;
    logic        mZ32, mN32, mV32;
    logic [5:0]  mO32;
    logic [7:0]  mF8;
    logic        mZ8, mN8, mV8;
    logic [3:0]  mO8;

    and32_bit dut32 (
        .clk       (clk),
        .rst_n     (rstN),
        .A         (opA),
        .B         (opB),
        .in_valid  (inValid),
        .F         (f32),
        .out_valid (valid32),
        .ZERO      (zero32),
        .NEG       (neg32),
        .ONES      (ones32)
    );

    and32_bit #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rstN),
        .A         (opA[7:0]),
        .B         (opB[7:0]),
        .in_valid  (inValid),
        .F         (f8),
        .out_valid (valid8),
        .ZERO      (zero8),
        .NEG       (neg8),
        .ONES      (ones8)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, advance the reference
    // model and push what both units must show after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic iv,
                                 input logic [31:0] a, input logic [31:0] b);
        logic [31:0] w;
        expT e;
        @(negedge clk);
        rstN    = rst;
        inValid = iv;
        opA     = a;
        opB     = b;
        w = a & b;
        if (!rst) begin
            mF32 = '0; mZ32 = 1'b1; mN32 = 1'b0; mO32 = '0; mV32 = 1'b0;
            mF8  = '0; mZ8  = 1'b1; mN8  = 1'b0; mO8  = '0; mV8  = 1'b0;
        end else if (iv) begin
            mF32 = w;      mZ32 = (w == 32'd0);     mN32 = w[31];
            mO32 = 6'($countones(w));      mV32 = 1'b1;
            mF8  = w[7:0]; mZ8  = (w[7:0] == 8'd0); mN8  = w[7];
            mO8  = 4'($countones(w[7:0])); mV8  = 1'b1;
        end else begin
            mV32 = 1'b0;
            mV8  = 1'b0;
        end
        e.f32 = mF32; e.z32 = mZ32; e.n32 = mN32; e.o32 = mO32; e.v32 = mV32;
        e.f8  = mF8;  e.z8  = mZ8;  e.n8  = mN8;  e.o8  = mO8;  e.v8  = mV8;
        sb.push_back(e);
    endtask

    // Monitor: one scoreboard entry is retired 1 time unit after each
    // rising edge, comparing every output of both units.
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("F32",     64'(f32),     64'(e.f32));
                checkOutput("ZERO32",  64'(zero32),  64'(e.z32));
                checkOutput("NEG32",   64'(neg32),   64'(e.n32));
                checkOutput("ONES32",  64'(ones32),  64'(e.o32));
                checkOutput("VALID32", 64'(valid32), 64'(e.v32));
                checkOutput("F8",      64'(f8),      64'(e.f8));
                checkOutput("ZERO8",   64'(zero8),   64'(e.z8));
                checkOutput("NEG8",    64'(neg8),    64'(e.n8));
                checkOutput("ONES8",   64'(ones8),   64'(e.o8));
                checkOutput("VALID8",  64'(valid8),  64'(e.v8));
            end
        end
    end

    logic [31:0] dirA [5] = '{32'd0, 32'd14, 32'd1, 32'd180, 32'd1543};
    logic [31:0] dirB [5] = '{32'd0, 32'd2,  32'd2, 32'd267, 32'd23};

    initial begin
        int validPulses;
        int waitCycles;
        rstN    = 1'b0;
        inValid = 1'b0;
        opA     = '0;
        opB     = '0;

        // Reset held for two cycles while valid all-ones operands are offered.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Directed vectors, back to back.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, dirA[i], dirB[i]);
        end

        // Extremes: all ones, then only the sign bit.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

        // Hold: one load, then junk operands with in_valid low.
        applyStimulus(1'b1, 1'b1, 32'd14, 32'd2);
        validPulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) applyStimulus(1'b1, 1'b0, $urandom, $urandom);
            @(posedge clk);
            #2;
            if (valid32) validPulses++;
        end
        checkOutput("HOLD_PULSES", 64'(validPulses), 64'd1);
        checkOutput("HOLD_F", 64'(f32), 64'd2);

        // Reset mid-stream with a valid result present.
        applyStimulus(1'b1, 1'b1, 32'd1543, 32'd23);
        applyStimulus(1'b0, 1'b1, 32'hF, 32'hF);
        applyStimulus(1'b1, 1'b0, 32'hF, 32'hF);
        applyStimulus(1'b1, 1'b1, 32'hF, 32'hF);

        // Random traffic with random in_valid and occasional resets.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 3) != 0),
                          $urandom, $urandom);
        end

        // Let the scoreboard drain, bounded.
        waitCycles = 0;
        while (sb.size() > 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("SB_DRAINED", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
